// File: rtl/roll_bcd_display_pkg.sv
// rtl/roll_bcd_display_pkg.sv - shared types, constants and segment encoding for roll_bcd_display
package roll_bcd_display_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DIGITS = 3;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high {g,f,e,d,c,b,a}; non-decimal codes go dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    seg_encode = 7'h3F;
            4'd1:    seg_encode = 7'h06;
            4'd2:    seg_encode = 7'h5B;
            4'd3:    seg_encode = 7'h4F;
            4'd4:    seg_encode = 7'h66;
            4'd5:    seg_encode = 7'h6D;
            4'd6:    seg_encode = 7'h7D;
            4'd7:    seg_encode = 7'h07;
            4'd8:    seg_encode = 7'h7F;
            4'd9:    seg_encode = 7'h6F;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD nibble to seven-segment pattern with blanking
module bcd_to_7seg
    import roll_bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : seg_encode(nibble);

endmodule

// File: rtl/roll_bcd_display.sv
// rtl/roll_bcd_display.sv - iterative binary-to-BCD converter driving a multiplexed 3-digit display
module roll_bcd_display
    import roll_bcd_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        value,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic [3:0]        bcd_hundreds,
    output logic [3:0]        bcd_tens,
    output logic [3:0]        bcd_ones,
    output logic [DIGITS-1:0] digit_en,
    output logic [6:0]        seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t      state, state_next;
    logic        start, finish;
    logic [2:0]  iter;
    logic [19:0] sr, adj, sr_shift;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (load) begin
                state_next = SHIFT;
                start      = 1'b1;
            end
            SHIFT: if (iter == 3'd7) begin
                state_next = IDLE;
                finish     = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble step: correct each BCD nibble before the shift would overflow it.
    always_comb begin
        adj = sr;
        if (sr[19:16] >= 4'd5) adj[19:16] = sr[19:16] + 4'd3;
        if (sr[15:12] >= 4'd5) adj[15:12] = sr[15:12] + 4'd3;
        if (sr[11:8]  >= 4'd5) adj[11:8]  = sr[11:8]  + 4'd3;
        sr_shift = {adj[18:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr           <= '0;
            iter         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bcd_hundreds <= '0;
            bcd_tens     <= '0;
            bcd_ones     <= '0;
        end else begin
            done <= finish;
            if (start) begin
                sr   <= {12'b0, value};
                iter <= '0;
                busy <= 1'b1;
            end else if (state == SHIFT) begin
                sr   <= sr_shift;
                iter <= iter + 3'd1;
                if (finish) begin
                    busy         <= 1'b0;
                    bcd_hundreds <= sr_shift[19:16];
                    bcd_tens     <= sr_shift[15:12];
                    bcd_ones     <= sr_shift[11:8];
                end
            end
        end
    end

    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx, idx_next;
    logic          advance;
    logic [3:0]    mux_nibble;
    logic          mux_blank;
    logic [6:0]    seg_next;

    assign advance = (scan_cnt == CW'(SCAN_DIV - 1));

    always_comb begin
        idx_next = idx;
        if (advance) idx_next = (idx == 2'(DIGITS - 1)) ? 2'd0 : idx + 2'd1;
    end

    // Mux and encoder look at the slot being entered so seg and digit_en move together.
    always_comb begin
        mux_nibble = bcd_ones;
        mux_blank  = 1'b0;
        case (idx_next)
            2'd1: begin
                mux_nibble = bcd_tens;
                mux_blank  = (bcd_hundreds == 4'd0) && (bcd_tens == 4'd0);
            end
            2'd2: begin
                mux_nibble = bcd_hundreds;
                mux_blank  = (bcd_hundreds == 4'd0);
            end
            default: ;
        endcase
    end

    bcd_to_7seg u_seg (
        .nibble (mux_nibble),
        .blank  (mux_blank),
        .seg    (seg_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            digit_en <= DIGITS'(1);
            seg      <= 7'h3F;
        end else begin
            scan_cnt <= advance ? '0 : scan_cnt + CW'(1);
            idx      <= idx_next;
            digit_en <= DIGITS'(1) << idx_next;
            seg      <= seg_next;
        end
    end

endmodule

// File: tb/tb_roll_bcd_display.sv
// tb/tb_roll_bcd_display.sv - directed self-checking bench for roll_bcd_display
module tb_roll_bcd_display;

    logic       clk;
    logic       reset;
    logic [7:0] value;
    logic       load;
    logic       busy;
    logic       done;
    logic [3:0] bcd_hundreds, bcd_tens, bcd_ones;
    logic [2:0] digit_en;
    logic [6:0] seg;

    int n_checks = 0;
    int n_fail   = 0;

    roll_bcd_display #(.SCAN_DIV(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .value        (value),
        .load         (load),
        .busy         (busy),
        .done         (done),
        .bcd_hundreds (bcd_hundreds),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones),
        .digit_en     (digit_en),
        .seg          (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input logic [7:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    // Counts busy samples until done, then checks digits and the one-cycle pulse width.
    task automatic wait_done(input string tag, input int exp_busy,
                             input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        int nb   = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                tick();
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, nb, exp_busy);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_digits"}, {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, {20'd0, h, t, o});
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic check_slot(input string tag, input logic [2:0] en, input logic [6:0] exp_seg);
        bit found = 1'b0;
        tick();
        for (int i = 0; i < 16 && !found; i++) begin
            if (digit_en == en) found = 1'b1;
            else tick();
        end
        check({tag, "_slot_found"}, 32'(found), 32'd1);
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    endtask

    initial begin
        logic [2:0] prev_en;
        logic [2:0] seq_en  [3];
        logic [6:0] seq_seg [3];
        bit   hit;
        int   n_done;

        reset = 1'b1;
        value = 8'd0;
        load  = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_digits", {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, 32'h000);
        check("rst_digit_en", 32'(digit_en), 32'h1);
        check("rst_seg", 32'(seg), 32'h3F);
        reset = 1'b0;

        start(8'd20);
        check("v20_busy_after_load", 32'(busy), 32'd1);
        wait_done("v20", 8, 4'd0, 4'd2, 4'd0);
        check_slot("v20_h", 3'b100, 7'h00);
        check_slot("v20_t", 3'b010, 7'h5B);
        check_slot("v20_o", 3'b001, 7'h3F);

        start(8'd255);
        wait_done("v255", 8, 4'd2, 4'd5, 4'd5);
        check_slot("v255_h", 3'b100, 7'h5B);
        check_slot("v255_t", 3'b010, 7'h6D);
        check_slot("v255_o", 3'b001, 7'h6D);

        start(8'd0);
        wait_done("v0", 8, 4'd0, 4'd0, 4'd0);
        check_slot("v0_h", 3'b100, 7'h00);
        check_slot("v0_t", 3'b010, 7'h00);
        check_slot("v0_o", 3'b001, 7'h3F);

        // Second load arrives after the third busy edge and must be dropped.
        start(8'd7);
        tick();
        tick();
        value = 8'd99;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        begin
            int nb   = 0;
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (done) seen = 1'b1;
                else begin
                    if (busy) nb++;
                    tick();
                end
            end
            check("ign_done_seen", 32'(seen), 32'd1);
            check("ign_busy_rest", nb, 5);
            check("ign_digits", {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, 32'h007);
        end
        // Still in the done cycle: this load is accepted.
        start(8'd99);
        check("dcyc_busy", 32'(busy), 32'd1);
        wait_done("dcyc", 8, 4'd0, 4'd9, 4'd9);

        start(8'd255);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_digits", {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, 32'h000);
        check("mid_rst_digit_en", 32'(digit_en), 32'h1);
        check("mid_rst_seg", 32'(seg), 32'h3F);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) n_done++;
        end
        check("mid_rst_no_done", n_done, 0);
        start(8'd128);
        wait_done("v128", 8, 4'd1, 4'd2, 4'd8);
        check_slot("v128_h", 3'b100, 7'h06);
        check_slot("v128_t", 3'b010, 7'h5B);
        check_slot("v128_o", 3'b001, 7'h7F);

        start(8'd105);
        wait_done("v105", 8, 4'd1, 4'd0, 4'd5);
        hit = 1'b0;
        for (int i = 0; i < 16 && !hit; i++) begin
            prev_en = digit_en;
            tick();
            if (digit_en == 3'b001 && prev_en != 3'b001) hit = 1'b1;
        end
        check("scan_sync", 32'(hit), 32'd1);
        check("scan_seg_ones", 32'(seg), 32'h6D);
        seq_en  = '{3'b010, 3'b100, 3'b001};
        seq_seg = '{7'h3F, 7'h06, 7'h6D};
        prev_en = 3'b001;
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            tick();
            check($sformatf("scan_hold%0d", k), 32'(digit_en), 32'(prev_en));
            tick();
            check($sformatf("scan_en%0d", k), 32'(digit_en), 32'(seq_en[k]));
            check($sformatf("scan_seg%0d", k), 32'(seg), 32'(seq_seg[k]));
            prev_en = seq_en[k];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
